// File: rtl/proj_read_streamer.sv
// Read streamer: buffers packed DNA words and serialises each read into
// exactly READ_LEN bases toward the minhash core, honouring its wait stall.
module proj_read_streamer #(
    parameter int BASE_LEN       = 2,
    parameter int BASES_PER_WORD = 16,
    parameter int READ_LEN       = 150,
    parameter int FIFO_DEPTH     = 4,
    localparam int WORD_W        = BASE_LEN * BASES_PER_WORD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [WORD_W-1:0]   s_data,
    input  logic                s_last,
    input  logic                core_wait,
    output logic [BASE_LEN-1:0] base_out,
    output logic                base_valid,
    output logic                start_out,
    output logic                read_done,
    output logic                err_len,
    output logic                busy
);

    localparam int WPR    = (READ_LEN + BASES_PER_WORD - 1) / BASES_PER_WORD;
    localparam int LAST_N = READ_LEN - (WPR - 1) * BASES_PER_WORD;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam int WIW    = $clog2(WPR + 1);
    localparam int BIW    = $clog2(BASES_PER_WORD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [WIW-1:0]      r_word_idx;
    logic [BIW-1:0]      r_base_idx;
    logic [WIW-1:0]      r_wr_cnt;

    logic                r_s_ready;
    logic [BASE_LEN-1:0] r_base_out;
    logic                r_base_valid;
    logic                r_start;
    logic                r_read_done;
    logic                r_err_len;
    logic                r_busy;

    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic                w_emit;
    logic                w_last_word;
    logic                w_word_end;
    logic                w_wr_last;
    logic [CW-1:0]       w_count_nxt;
    logic [WORD_W-1:0]   w_head;
    logic [BASE_LEN-1:0] w_base;

    assign w_empty     = (r_count == '0);
    assign w_push      = s_valid && r_s_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_last_word = (r_word_idx == WIW'(WPR - 1));
    assign w_word_end  = w_last_word ? (r_base_idx == BIW'(LAST_N - 1))
                                     : (r_base_idx == BIW'(BASES_PER_WORD - 1));
    assign w_emit      = (r_state == S_STREAM) && !core_wait && !w_empty;
    // Word leaves the FIFO on its last used base; tail bases are dropped.
    assign w_pop       = w_emit && w_word_end;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_wr_last   = (r_wr_cnt == WIW'(WPR - 1));

    always_comb begin
        w_base = w_head[int'(r_base_idx) * BASE_LEN +: BASE_LEN];
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty && !core_wait)
                    w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (w_pop && w_last_word)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                // A queued read may start straight away to keep reads back-to-back.
                if (!w_empty && !core_wait)
                    w_state_nxt = S_STREAM;
                else
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_word_idx   <= '0;
            r_base_idx   <= '0;
            r_wr_cnt     <= '0;
            r_s_ready    <= 1'b1;
            r_base_out   <= '0;
            r_base_valid <= 1'b0;
            r_start      <= 1'b0;
            r_read_done  <= 1'b0;
            r_err_len    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_s_ready    <= (w_count_nxt != CW'(FIFO_DEPTH));
            r_busy       <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
            r_base_valid <= w_emit;
            r_start      <= w_emit && (r_word_idx == '0) && (r_base_idx == '0);
            r_read_done  <= (r_state == S_DONE);
            r_err_len    <= 1'b0;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                if (s_last != w_wr_last) begin
                    r_err_len <= 1'b1;
                    r_wr_cnt  <= '0;
                end else if (w_wr_last) begin
                    r_wr_cnt  <= '0;
                end else begin
                    r_wr_cnt  <= r_wr_cnt + WIW'(1);
                end
            end

            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);

            if (w_emit) begin
                r_base_out <= w_base;
                if (w_word_end) begin
                    r_base_idx <= '0;
                    r_word_idx <= w_last_word ? '0 : r_word_idx + WIW'(1);
                end else begin
                    r_base_idx <= r_base_idx + BIW'(1);
                end
            end
        end
    end

    assign s_ready    = r_s_ready;
    assign base_out   = r_base_out;
    assign base_valid = r_base_valid;
    assign start_out  = r_start;
    assign read_done  = r_read_done;
    assign err_len    = r_err_len;
    assign busy       = r_busy;

endmodule

// File: tb/tb_proj_read_streamer.sv
// Bench for proj_read_streamer: vector table of read scenarios plus
// hand-written back-to-back and mid-read reset sequences, scoreboard checked.
module tb_proj_read_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        core_wait = 1'b0;
    logic [1:0]  base_out;
    logic        base_valid;
    logic        start_out;
    logic        read_done;
    logic        err_len;
    logic        busy;

    proj_read_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .core_wait  (core_wait),
        .base_out   (base_out),
        .base_valid (base_valid),
        .start_out  (start_out),
        .read_done  (read_done),
        .err_len    (err_len),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] b;
        bit         st;
        bit         lst;
    } exp_t;

    typedef struct {
        int words;
        int last_at;
        int gap;
        int wait_at;
        int pat;
        int err;
        int reads;
    } vec_t;

    exp_t q[$];
    int   start_cyc[$];
    int   last_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ew = 0;
    int   nb = 0;
    int   n_start = 0;
    int   n_done = 0;
    int   n_err = 0;
    int   last_cyc = -100;
    int   wait_at = -1;
    int   wait_len = 0;
    int   wait_cnt = 0;
    bit   resume_chk = 0;
    logic [1:0] held = '0;
    bit   first_push = 0;
    int   push_cyc0 = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_push(input logic [31:0] d);
        int n;
        exp_t e;
        n = (ew == 9) ? 6 : 16;
        for (int k = 0; k < n; k++) begin
            e.b   = d[k*2 +: 2];
            e.st  = (ew == 0 && k == 0);
            e.lst = (ew == 9 && k == 5);
            q.push_back(e);
        end
        ew = (ew == 9) ? 0 : ew + 1;
    endtask

    task automatic clear_model();
        q.delete();
        start_cyc.delete();
        last_q.delete();
        ew = 0;
        nb = 0;
        n_start = 0;
        n_done = 0;
        n_err = 0;
        last_cyc = -100;
        wait_at = -1;
        wait_cnt = 0;
        resume_chk = 0;
        first_push = 1;
    endtask

    task automatic push_word(input logic [31:0] d, input bit l);
        int t = 0;
        while (!s_ready && t < 5000) begin
            s_valid = 1'b0;
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("push_timeout", 1, 0);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        if (first_push) begin
            push_cyc0  = cyc;
            first_push = 0;
        end
        model_push(d);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        core_wait = 1'b0;
        @(negedge clk);
        clear_model();
        chk("rst_base_out", base_out, 0);
        chk("rst_base_valid", base_valid, 0);
        chk("rst_start", start_out, 0);
        chk("rst_done", read_done, 0);
        chk("rst_err", err_len, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", s_ready, 1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_reads(input int reads);
        int t = 0;
        while ((n_done < reads || q.size() != 0) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", t < 4000, 1);
        repeat (3) @(negedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (wait_cnt > 0) begin
                chk("wait_valid", base_valid, 0);
                chk("wait_hold", base_out, held);
                wait_cnt--;
                if (wait_cnt == 0) begin
                    core_wait  = 1'b0;
                    resume_chk = 1;
                end
            end else if (resume_chk) begin
                chk("wait_resume", base_valid, 1);
                resume_chk = 0;
            end
            if (base_valid) begin
                if (q.size() == 0) begin
                    chk("extra_base", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("base", base_out, e.b);
                    chk("start_flag", start_out, e.st);
                    if (e.lst) begin
                        last_cyc = cyc;
                        last_q.push_back(cyc);
                    end
                    nb++;
                    if (nb - 1 == wait_at) begin
                        core_wait = 1'b1;
                        wait_cnt  = wait_len;
                        held      = base_out;
                    end
                end
            end else if (start_out) begin
                chk("start_without_base", 1, 0);
            end
            if (start_out) begin
                n_start++;
                start_cyc.push_back(cyc);
            end
            if (read_done) begin
                n_done++;
                chk("done_timing", cyc, last_cyc + 1);
            end
            if (err_len) n_err++;
        end
    end

    vec_t vecs[6];

    initial begin
        // words last_at gap wait_at pat err reads
        vecs[0] = '{10,  9,  0, -1, 0, 0, 1};
        vecs[1] = '{10,  9,  0, 40, 1, 0, 1};
        vecs[2] = '{10,  9, 20, -1, 1, 0, 1};
        vecs[3] = '{10,  5,  0, -1, 1, 1, 1};
        vecs[4] = '{10, -1,  0, -1, 1, 1, 1};
        vecs[5] = '{20,  9,  0, -1, 1, 0, 2};
        wait_len = 5;

        for (int v = 0; v < 6; v++) begin
            do_reset();
            wait_at = vecs[v].wait_at;
            for (int i = 0; i < vecs[v].words; i++) begin
                logic [31:0] d;
                d = (vecs[v].pat == 0) ? 32'hE4E4_E4E4 : $urandom;
                push_word(d, (i % 10) == vecs[v].last_at);
                repeat (vecs[v].gap) @(negedge clk);
            end
            wait_reads(vecs[v].reads);
            chk($sformatf("v%0d_bases", v), nb, 150 * vecs[v].reads);
            chk($sformatf("v%0d_starts", v), n_start, vecs[v].reads);
            chk($sformatf("v%0d_dones", v), n_done, vecs[v].reads);
            chk($sformatf("v%0d_errs", v), n_err, vecs[v].err);
            chk($sformatf("v%0d_idle", v), busy, 0);
            if (start_cyc.size() > 0)
                chk($sformatf("v%0d_latency", v), start_cyc[0] - push_cyc0, 3);
        end

        // Preloaded back-to-back reads with the FIFO held full.
        do_reset();
        core_wait = 1'b1;
        for (int i = 0; i < 4; i++) push_word($urandom, 1'b0);
        chk("full_ready", s_ready, 0);
        chk("full_busy", busy, 1);
        chk("full_no_start", start_out, 0);
        core_wait = 1'b0;
        for (int i = 4; i < 20; i++) push_word($urandom, (i % 10) == 9);
        wait_reads(2);
        chk("b2b_starts", n_start, 2);
        chk("b2b_dones", n_done, 2);
        chk("b2b_errs", n_err, 0);
        if (start_cyc.size() == 2 && last_q.size() >= 1)
            chk("b2b_gap", start_cyc[1] - last_q[0], 2);
        else
            chk("b2b_gap_missing", 1, 0);

        // Reset in the middle of a read.
        do_reset();
        for (int i = 0; i < 6; i++) push_word(32'hE4E4_E4E4, 1'b0);
        begin
            int t = 0;
            while (nb < 78 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            chk("mid_timeout", t < 2000, 1);
        end
        #1 rst = 1'b1;
        #1;
        chk("mid_base_out", base_out, 0);
        chk("mid_valid", base_valid, 0);
        chk("mid_start", start_out, 0);
        chk("mid_done", read_done, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", s_ready, 1);
        chk("mid_no_done", n_done, 0);
        @(negedge clk);
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_done", n_done, 0);
        for (int i = 0; i < 10; i++) push_word(32'hE4E4_E4E4, i == 9);
        wait_reads(1);
        chk("fresh_bases", nb, 150);
        chk("fresh_starts", n_start, 1);
        chk("fresh_dones", n_done, 1);
        chk("fresh_errs", n_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
